// File: rtl/board_pkg.sv
// Shared types and constants for the board display path: cell codes, VGA
// 640x480@60 timing, colours and the per-pixel metadata carried down the pipeline.
package board_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_TRIG  = 2'b01,
      CELL_CIRC  = 2'b10,
      CELL_MARK  = 2'b11
   } cell_t;

   localparam int BOARD_N = 10;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Width of the in-cell offsets; cells up to 64 px are representable.
   localparam int OFF_W = 6;

   localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
   localparam logic [23:0] COL_RED   = 24'hFF0000;
   localparam logic [23:0] COL_BLUE  = 24'h0000FF;
   localparam logic [23:0] COL_GREEN = 24'h00FF00;
   localparam logic [23:0] COL_BLACK = 24'h000000;
   localparam logic [23:0] COL_GRAY  = 24'h202020;

   typedef struct packed {
      logic [OFF_W-1:0] u;
      logic [OFF_W-1:0] v;
      logic             in_board;
      logic             grid;
      logic             hs;
      logic             vs;
      logic             vis;
   } pix_meta_t;

endpackage

// File: rtl/board_renderer_vga_timing.sv
// Pixel-tick divider and 800x525 scan counters with raw (undelayed) sync,
// visible-area flag and the frame_start pulse.
module vga_timing
   import board_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       visible,
   output logic       frame_start
);
   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_reg;
   logic [9:0]    hcnt_reg;
   logic [9:0]    vcnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg  <= '0;
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else begin
         div_reg <= (div_reg == DW'(CLK_DIV - 1)) ? '0 : div_reg + 1'b1;
         if (tick) begin
            if (hcnt_reg == 10'(H_TOTAL - 1)) begin
               hcnt_reg <= '0;
               vcnt_reg <= (vcnt_reg == 10'(V_TOTAL - 1)) ? '0 : vcnt_reg + 1'b1;
            end else begin
               hcnt_reg <= hcnt_reg + 1'b1;
            end
         end
      end
   end

   // The divider sits at 0 in reset, so tick (and frame_start) stay low there.
   assign tick        = (div_reg == DW'(CLK_DIV - 1));
   assign hcnt        = hcnt_reg;
   assign vcnt        = vcnt_reg;
   assign hsync_raw   = !((hcnt_reg >= 10'(H_VISIBLE + H_FRONT)) &&
                          (hcnt_reg <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
   assign vsync_raw   = !((vcnt_reg >= 10'(V_VISIBLE + V_FRONT)) &&
                          (vcnt_reg <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
   assign visible     = (hcnt_reg < 10'(H_VISIBLE)) && (vcnt_reg < 10'(V_VISIBLE));
   assign frame_start = tick && (hcnt_reg == '0) && (vcnt_reg == '0);

endmodule

// File: rtl/board_renderer.sv
// Renders the 10x10 board as a grid with one shape per cell; three tick-aligned
// register stages: address, cell capture, colour/sync output.
module board_renderer
   import board_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int BOARD_X0 = 120,
   parameter int BOARD_Y0 = 40,
   parameter int CELL_PX  = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] q_a,
   output logic [6:0] addr_x,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       frame_start
);
   localparam int               BOARD_PX = BOARD_N * CELL_PX;
   localparam logic [9:0]       X_FIRST  = 10'(BOARD_X0);
   localparam logic [9:0]       X_LAST   = 10'(BOARD_X0 + BOARD_PX - 1);
   localparam logic [9:0]       Y_FIRST  = 10'(BOARD_Y0);
   localparam logic [9:0]       Y_LAST   = 10'(BOARD_Y0 + BOARD_PX - 1);
   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CELL_PX - 1);
   localparam logic [6:0]       ROW_STEP = 7'(BOARD_N);
   localparam pix_meta_t META_RESET = '{u: '0, v: '0, in_board: 1'b0, grid: 1'b0,
                                        hs: 1'b1, vs: 1'b1, vis: 1'b0};

   logic       tick;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       hsync_raw;
   logic       vsync_raw;
   logic       visible;

   vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .hcnt       (hcnt),
      .vcnt       (vcnt),
      .hsync_raw  (hsync_raw),
      .vsync_raw  (vsync_raw),
      .visible    (visible),
      .frame_start(frame_start)
   );

   // Cell position counters track the current hcnt/vcnt without any division.
   logic [OFF_W-1:0] u_reg;
   logic [OFF_W-1:0] v_reg;
   logic [3:0]       col_reg;
   logic [6:0]       row_base_reg;
   logic             h_in;
   logic             v_in;
   logic             in_board;

   assign h_in     = (hcnt >= X_FIRST) && (hcnt <= X_LAST);
   assign v_in     = (vcnt >= Y_FIRST) && (vcnt <= Y_LAST);
   assign in_board = h_in && v_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         u_reg        <= '0;
         v_reg        <= '0;
         col_reg      <= '0;
         row_base_reg <= '0;
      end else if (tick) begin
         if (h_in && (hcnt != X_LAST)) begin
            if (u_reg == OFF_LAST) begin
               u_reg   <= '0;
               col_reg <= col_reg + 1'b1;
            end else begin
               u_reg <= u_reg + 1'b1;
            end
         end else begin
            u_reg   <= '0;
            col_reg <= '0;
         end
         if (hcnt == 10'(H_TOTAL - 1)) begin
            if (v_in && (vcnt != Y_LAST)) begin
               if (v_reg == OFF_LAST) begin
                  v_reg        <= '0;
                  row_base_reg <= row_base_reg + ROW_STEP;
               end else begin
                  v_reg <= v_reg + 1'b1;
               end
            end else begin
               v_reg        <= '0;
               row_base_reg <= '0;
            end
         end
      end
   end

   pix_meta_t meta_s0;
   always_comb begin
      meta_s0          = META_RESET;
      meta_s0.u        = u_reg;
      meta_s0.v        = v_reg;
      meta_s0.in_board = in_board;
      meta_s0.grid     = (u_reg == '0) || (v_reg == '0) || (hcnt == X_LAST) || (vcnt == Y_LAST);
      meta_s0.hs       = hsync_raw;
      meta_s0.vs       = vsync_raw;
      meta_s0.vis      = visible;
   end

   logic [6:0] addr_reg;
   pix_meta_t  meta_pipe [0:1];
   cell_t      cell_reg;
   logic [23:0] rgb_reg;
   logic        hsync_reg;
   logic        vsync_reg;
   logic        blank_reg;
   logic [23:0] pix_colour;

   // meta_pipe[1] and cell_reg describe the same pixel when stage 2 samples them.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg     <= '0;
         meta_pipe[0] <= META_RESET;
         meta_pipe[1] <= META_RESET;
         cell_reg     <= CELL_EMPTY;
         rgb_reg      <= COL_BLACK;
         hsync_reg    <= 1'b1;
         vsync_reg    <= 1'b1;
         blank_reg    <= 1'b0;
      end else if (tick) begin
         addr_reg     <= in_board ? (row_base_reg + 7'(col_reg)) : '0;
         meta_pipe[0] <= meta_s0;
         meta_pipe[1] <= meta_pipe[0];
         cell_reg     <= cell_t'(q_a);
         rgb_reg      <= pix_colour;
         hsync_reg    <= meta_pipe[1].hs;
         vsync_reg    <= meta_pipe[1].vs;
         blank_reg    <= meta_pipe[1].vis;
      end
   end

   // Shape geometry is centred on offset 20 of a 40 px cell.
   logic signed [6:0] du;
   logic signed [6:0] dv;
   logic [5:0]        du_abs;
   logic [5:0]        dv_abs;
   logic [10:0]       dist_sq;
   logic              tri_hit;
   logic              circ_hit;
   logic              mark_hit;

   assign du       = $signed({1'b0, meta_pipe[1].u}) - 7'sd20;
   assign dv       = $signed({1'b0, meta_pipe[1].v}) - 7'sd20;
   assign du_abs   = du[6] ? 6'(-du) : 6'(du);
   assign dv_abs   = dv[6] ? 6'(-dv) : 6'(dv);
   assign dist_sq  = 11'(du_abs) * 11'(du_abs) + 11'(dv_abs) * 11'(dv_abs);
   assign tri_hit  = (meta_pipe[1].v >= 6'd5) && (meta_pipe[1].v <= 6'd34) &&
                     ({du_abs, 1'b0} <= ({1'b0, meta_pipe[1].v} - 7'd5));
   assign circ_hit = (dist_sq >= 11'd196) && (dist_sq <= 11'd289);
   assign mark_hit = (meta_pipe[1].u >= 6'd8) && (meta_pipe[1].u <= 6'd31) &&
                     (meta_pipe[1].v >= 6'd8) && (meta_pipe[1].v <= 6'd31);

   always_comb begin
      pix_colour = COL_BLACK;
      if (!meta_pipe[1].vis) begin
         pix_colour = COL_BLACK;
      end else if (!meta_pipe[1].in_board) begin
         pix_colour = COL_GRAY;
      end else if (meta_pipe[1].grid) begin
         pix_colour = COL_WHITE;
      end else begin
         case (cell_reg)
            CELL_TRIG: pix_colour = tri_hit  ? COL_RED   : COL_BLACK;
            CELL_CIRC: pix_colour = circ_hit ? COL_BLUE  : COL_BLACK;
            CELL_MARK: pix_colour = mark_hit ? COL_GREEN : COL_BLACK;
            default:   pix_colour = COL_BLACK;
         endcase
      end
   end

   assign addr_x  = addr_reg;
   assign hsync   = hsync_reg;
   assign vsync   = vsync_reg;
   assign blank_n = blank_reg;
   assign vga_r   = rgb_reg[23:16];
   assign vga_g   = rgb_reg[15:8];
   assign vga_b   = rgb_reg[7:0];

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench: a geometric model of the screen, indexed by clocks since
// reset release, is compared against the renderer every clock.
module tb_board_renderer;
   localparam int CLK_DIV = 2;
   localparam int X0      = 120;
   localparam int Y0      = 2;     // board pulled up so rows 0..1 are reached quickly
   localparam int CP      = 40;
   localparam int END_E   = 2 * 44 * 800 + 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] q_a = 2'b00;
   logic [6:0] addr_x;
   logic       hsync, vsync, blank_n, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;

   board_renderer #(.CLK_DIV(CLK_DIV), .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_PX(CP)) dut (
      .clk(clk), .rst(rst), .q_a(q_a), .addr_x(addr_x), .hsync(hsync), .vsync(vsync),
      .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
   );

   always #10 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   logic [1:0] board [0:99];
   int   e = 0;
   bit   armed = 0;
   bit   seg2 = 0;
   int   lit_hits = 0;

   int          lit_x   [12] = '{243, 260, 140, 140, 500, 519, 520, 120, 100, 700, 140, 140};
   int          lit_y   [12] = '{ 27,  27,   5,  22,  22,  22,  22,  22,  22,  22,   2,   1};
   logic [23:0] lit_rgb [12] = '{24'h000000, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h00FF00,
                                 24'hFFFFFF, 24'h202020, 24'hFFFFFF, 24'h202020, 24'h000000,
                                 24'hFFFFFF, 24'h202020};
   int          lit_ax  [4]  = '{243, 500, 100, 140};
   int          lit_ay  [4]  = '{ 27,  22,  22,  42};
   int          lit_a   [4]  = '{  3,   9,   0,  10};

   // Clocks since the last clock edge that sampled reset high.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         e = 0;
         armed = 1;
      end else begin
         e = e + 1;
      end
   end

   // Controller read port: registered read, data one clock after the address.
   initial begin
      logic [6:0] a_hold;
      forever begin
         @(negedge clk);
         a_hold = addr_x;
         @(posedge clk);
         #1;
         q_a = (a_hold < 7'd100) ? board[a_hold] : 2'b00;
      end
   end

   function automatic bit on_board(int x, int y);
      return (x >= X0) && (x <= X0 + 399) && (y >= Y0) && (y <= Y0 + 399);
   endfunction

   function automatic int model_addr(int x, int y);
      if (!on_board(x, y)) return 0;
      return ((y - Y0) / CP) * 10 + (x - X0) / CP;
   endfunction

   function automatic logic [23:0] model_rgb(int x, int y);
      int u, v, du, dv, adu;
      logic [1:0] c;
      if (x >= 640 || y >= 480) return 24'h000000;
      if (!on_board(x, y)) return 24'h202020;
      u = (x - X0) % CP;
      v = (y - Y0) % CP;
      if (u == 0 || v == 0 || x == X0 + 399 || y == Y0 + 399) return 24'hFFFFFF;
      c = board[model_addr(x, y)];
      du = u - 20;
      dv = v - 20;
      adu = (du < 0) ? -du : du;
      case (c)
         2'b01: if (v >= 5 && v <= 34 && 2 * adu <= v - 5) return 24'hFF0000;
         2'b10: if (du * du + dv * dv >= 196 && du * du + dv * dv <= 289) return 24'h0000FF;
         2'b11: if (u >= 8 && u <= 31 && v >= 8 && v <= 31) return 24'h00FF00;
         default: ;
      endcase
      return 24'h000000;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at clk %0d: got=%h expected=%h", name, e, got, exp);
      end
   endtask

   task automatic randomize_board();
      for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(0, 3));
      board[0] = 2'b10;
      board[3] = 2'b01;
      board[9] = 2'b11;
   endtask

   // Per-clock comparison against the model.
   initial begin
      int  hs_low = 0;
      int  last_fall = -1;
      bit  prev_hs = 1'b1;
      forever begin
         @(negedge clk);
         if (armed) begin
            int x, y, k;
            logic [26:0] got_out, exp_out;
            logic [23:0] rgb_now;
            logic        fs_exp;
            logic [6:0]  a_exp;
            rgb_now = {vga_r, vga_g, vga_b};
            got_out = {hsync, vsync, blank_n, rgb_now};
            if (e == 0) begin
               exp_out = {1'b1, 1'b1, 1'b0, 24'h0};
               a_exp = 7'd0;
               fs_exp = 1'b0;
               hs_low = 0;
               last_fall = -1;
            end else begin
               fs_exp = (e % 2 == 1) && ((e / 2) % 420000 == 0);
               if (e >= 2) begin
                  k = e / 2 - 1;
                  x = k % 800;
                  y = (k / 800) % 525;
                  a_exp = 7'(model_addr(x, y));
                  if (e % 2 == 0) begin
                     for (int i = 0; i < 4; i++) begin
                        if (x == lit_ax[i] && y == lit_ay[i]) begin
                           $display("addr (%0d,%0d) got=%0d expected=%0d", x, y, addr_x, lit_a[i]);
                           chk("addr_literal", 32'(addr_x), 32'(lit_a[i]));
                           if (seg2) lit_hits++;
                        end
                     end
                  end
               end else begin
                  a_exp = 7'd0;
               end
               if (e >= 6) begin
                  k = e / 2 - 3;
                  x = k % 800;
                  y = (k / 800) % 525;
                  exp_out = {!(x >= 656 && x <= 751), !(y >= 490 && y <= 491),
                             (x < 640 && y < 480), model_rgb(x, y)};
                  if (e % 2 == 0) begin
                     for (int i = 0; i < 12; i++) begin
                        if (x == lit_x[i] && y == lit_y[i]) begin
                           $display("pixel (%0d,%0d) rgb=%h expected=%h", x, y, rgb_now, lit_rgb[i]);
                           chk("rgb_literal", 32'(rgb_now), 32'(lit_rgb[i]));
                           if (seg2) lit_hits++;
                        end
                     end
                  end
                  if (prev_hs && !hsync) begin
                     if (last_fall >= 0) chk("hsync_period_clks", 32'(e - last_fall), 32'd1600);
                     last_fall = e;
                  end
                  if (!hsync) hs_low++;
                  if (!prev_hs && hsync) begin
                     chk("hsync_low_clks", 32'(hs_low), 32'd192);
                     hs_low = 0;
                  end
               end else begin
                  exp_out = {1'b1, 1'b1, 1'b0, 24'h0};
               end
            end
            chk("sync_blank_rgb", 32'(got_out), 32'(exp_out));
            chk("addr_x", 32'(addr_x), 32'(a_exp));
            chk("frame_start", 32'(frame_start), 32'(fs_exp));
            if (!blank_n) chk("rgb_in_blank", 32'(rgb_now), 32'd0);
            prev_hs = hsync;
         end
      end
   end

   initial begin
      randomize_board();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      // Counters at hcnt=300, vcnt=3 after this many clocks.
      while (e < 5400) @(negedge clk);
      $display("mid-frame reset at clk %0d", e);
      rst = 1'b1;
      @(negedge clk);
      randomize_board();
      rst = 1'b0;
      seg2 = 1;
      while (e < END_E) @(negedge clk);
      chk("literal_coverage", 32'(lit_hits), 32'd16);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
